// File: rtl/cond_unit_pkg.sv
// ============================================================================
// Module      : cond_unit_pkg
// Description : Shared constants for the ARM condition unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cond_unit_pkg;

    localparam int FLAG_BITS = 4;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW fields: [1] selects the N,Z group, [0] selects the C,V group
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

`default_nettype wire

// File: rtl/cond_unit_cond_check.sv
// ============================================================================
// Module      : cond_check
// Description : Pure combinational decode of the ARM condition field.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0]           Cond,
    input  logic [FLAG_BITS-1:0] Flags,
    output logic                 CondEx
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = Flags[FLAG_N];
    assign w_z = Flags[FLAG_Z];
    assign w_c = Flags[FLAG_C];
    assign w_v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            COND_EQ: CondEx = w_z;
            COND_NE: CondEx = ~w_z;
            COND_CS: CondEx = w_c;
            COND_CC: CondEx = ~w_c;
            COND_MI: CondEx = w_n;
            COND_PL: CondEx = ~w_n;
            COND_VS: CondEx = w_v;
            COND_VC: CondEx = ~w_v;
            COND_HI: CondEx = w_c & ~w_z;
            COND_LS: CondEx = ~w_c | w_z;
            COND_GE: CondEx = (w_n == w_v);
            COND_LT: CondEx = (w_n != w_v);
            COND_GT: CondEx = ~w_z & (w_n == w_v);
            COND_LE: CondEx = w_z | (w_n != w_v);
            // AL and the unused 1111 encoding both always execute
            default: CondEx = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cond_unit.sv
// ============================================================================
// Module      : cond_unit
// Description : ARM flags register, condition evaluation and write gating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int                FLAG_W      = FLAG_BITS,
    parameter logic [FLAG_W-1:0] RESET_FLAGS = '0
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              En,
    input  logic              Flush,
    input  logic [3:0]        Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              CondEx,
    output logic [FLAG_W-1:0] Flags
);

    logic [FLAG_W-1:0] r_flags;
    logic              w_pass;
    logic              w_live;

    // Evaluated against the stored flags only: no same-cycle bypass from ALUFlags
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (r_flags),
        .CondEx (w_pass)
    );

    assign w_live = En & ~Flush & Reset_n;

    assign CondEx   = w_pass & Reset_n;
    assign PCSrc    = PCS  & w_pass & w_live;
    assign RegWrite = RegW & w_pass & ~NoWrite & w_live;
    assign MemWrite = MemW & w_pass & w_live;
    assign Flags    = r_flags;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_flags <= RESET_FLAGS;
        end else if (w_live && w_pass) begin
            if (FlagW[FLAGW_NZ]) begin
                r_flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            end
            if (FlagW[FLAGW_CV]) begin
                r_flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cond_unit.sv
// ============================================================================
// Module      : tb_cond_unit
// Description : Self-checking bench for cond_unit (vector table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_unit;

    logic       CLK;
    logic       Reset_n;
    logic       En;
    logic       Flush;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    int total = 0;
    int bad   = 0;

    cond_unit dut (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .En       (En),
        .Flush    (Flush),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] pre;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       en;
        logic       flush;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       nowrite;
        logic [3:0] exp_wr;    // {PCSrc, RegWrite, MemWrite, CondEx}
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                         input logic e, input logic fl, input logic p, input logic r,
                         input logic m, input logic nw);
        Cond = c; ALUFlags = a; FlagW = fw; En = e; Flush = fl;
        PCS = p; RegW = r; MemW = m; NoWrite = nw;
    endtask

    // Loads the flags register through an AL instruction with both groups selected
    task automatic preload(input logic [3:0] f);
        drive(4'b1110, f, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cc && !z;
            4'd9:  return !cc || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        //             pre      cond     alu      fw     en    fl    pcs   regw  memw  nw    {pc,rw,mw,cx} flags
        vecs[0]  = '{4'b0000, 4'b1110, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0100};
        vecs[1]  = '{4'b1010, 4'b1110, 4'b0101, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'b1001};
        vecs[2]  = '{4'b1001, 4'b1110, 4'b0100, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b0101};
        vecs[3]  = '{4'b0000, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b0011, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0011};
        vecs[5]  = '{4'b0011, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0011};
        vecs[6]  = '{4'b0011, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0011};
        vecs[7]  = '{4'b1001, 4'b1100, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b1001};
        vecs[8]  = '{4'b1000, 4'b1101, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b1000};
        vecs[9]  = '{4'b0110, 4'b1000, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0110};
        vecs[10] = '{4'b0000, 4'b1111, 4'b1010, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b1010};
        vecs[11] = '{4'b0000, 4'b0100, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000};

        // Reset held while inputs toggle and request updates/writes
        Reset_n = 1'b0;
        drive(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            ALUFlags = ~ALUFlags;
            #1;
            chk("reset_flags", Flags, 4'b0000);
            chk("reset_wr", {PCSrc, RegWrite, MemWrite, CondEx}, 4'b0000);
        end
        drive(4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        Reset_n = 1'b1;
        #1;
        chk("post_reset_regwrite", {3'b000, RegWrite}, 4'b0001);

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            preload(vecs[i].pre);
            drive(vecs[i].cond, vecs[i].alu, vecs[i].fw, vecs[i].en, vecs[i].flush,
                  vecs[i].pcs, vecs[i].regw, vecs[i].memw, vecs[i].nowrite);
            #1;
            chk($sformatf("vec%0d_wr", i), {PCSrc, RegWrite, MemWrite, CondEx}, vecs[i].exp_wr);
            tick();
            chk($sformatf("vec%0d_flags", i), Flags, vecs[i].exp_flags);
        end

        // CMP sets Z, then EQ branch taken next cycle / NE branch not taken
        for (int k = 0; k < 2; k++) begin
            preload(4'b0000);
            drive(4'b1110, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            #1;
            chk("cmp_regwrite", {3'b000, RegWrite}, 4'b0000);
            tick();
            chk("cmp_flags", Flags, 4'b0100);
            drive((k == 0) ? 4'b0000 : 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            chk(k == 0 ? "beq_pcsrc" : "bne_pcsrc", {3'b000, PCSrc}, (k == 0) ? 4'b0001 : 4'b0000);
            tick();
        end

        // Stall, flush, then the same update goes through
        preload(4'b0000);
        drive(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stall_hold", Flags, 4'b0000);
        Flush = 1'b1; En = 1'b1;
        tick();
        chk("flush_hold", Flags, 4'b0000);
        Flush = 1'b0;
        tick();
        chk("resume_update", Flags, 4'b1111);

        // No same-cycle bypass: CondEx sees stored flags, not ALUFlags
        preload(4'b0000);
        drive(4'b0000, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("no_bypass", {3'b000, CondEx}, 4'b0000);

        // Asynchronous reset mid-instruction drops the pending update
        preload(4'b1111);
        drive(4'b1110, 4'b0101, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_reset_flags", Flags, 4'b0000);
        chk("async_reset_wr", {PCSrc, RegWrite, MemWrite, CondEx}, 4'b0000);
        tick();
        chk("async_reset_edge", Flags, 4'b0000);
        Reset_n = 1'b1;
        #1;

        // Exhaustive condition decode over all stored-flag values
        for (int f = 0; f < 16; f++) begin
            preload(4'(f));
            drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c);
                #1;
                chk($sformatf("decode_c%0d_f%0d", c, f), {3'b000, CondEx},
                    {3'b000, ref_cond(4'(c), 4'(f))});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumes the 4-bit ALU status flags {N,Z,C,V} and holds them in an architectural flags register.
- Evaluates the 4-bit ARM condition field of each instruction against the stored flags.
- Gates the instruction's PC, register and memory write enables according to that result.
- Sits between the decoder/ALU and the register file, memory and PC mux of the ARM core.

Parameters:
- FLAG_W, 4, flag vector width {N,Z,C,V}; fixed, not overridable in practice.
- RESET_FLAGS, 4'b0000, flags register value after reset.

Ports:
- CLK  input  1  core clock; all state changes on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- En  input  1  stage enable; 0 = stall (no state change, all write outputs forced 0).
- Flush  input  1  squash current instruction; all write outputs 0, no flag update.
- Cond  input  4  instruction condition field Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from ALU for the current instruction.
- FlagW  input  2  [1] = update N,Z; [0] = update C,V.
- PCS  input  1  decoder: instruction writes PC.
- RegW  input  1  decoder: instruction writes register file.
- MemW  input  1  decoder: instruction writes memory.
- NoWrite  input  1  decoder: compare-type instruction (CMP/CMN/TST); suppresses RegWrite only.
- PCSrc  output  1  gated PC write.
- RegWrite  output  1  gated register write.
- MemWrite  output  1  gated memory write.
- CondEx  output  1  condition-pass result, for debug/trace.
- Flags  output  4  current contents of the flags register.

Behaviour:
- Reset: Flags = RESET_FLAGS, asynchronously on Reset_n = 0. While in reset, PCSrc, RegWrite, MemWrite and CondEx are all 0.
- CondEx is combinational from Cond and the registered Flags (the pre-update value). It is not computed from ALUFlags.
- Condition codes, with F = Flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: treated as AL (1). Never X.
- Define live = En & !Flush & Reset_n.
- Write gating, combinational, zero latency:
  - PCSrc = PCS & CondEx & live
  - RegWrite = RegW & CondEx & !NoWrite & live
  - MemWrite = MemW & CondEx & live
- Flag update on the rising edge when live & CondEx:
  - If FlagW[1]: Flags[3:2] <= ALUFlags[3:2].
  - If FlagW[0]: Flags[1:0] <= ALUFlags[1:0].
  - Each group updates independently. Unselected groups hold their value.
- Flags are not updated when the condition fails, when En = 0, or when Flush = 1. Flush takes priority over En.
- An instruction's flag update becomes visible to CondEx on the next cycle only. There is no same-cycle bypass; the decoder guarantees ordering.
- Reset asserted mid-instruction: Flags go to RESET_FLAGS immediately, and any pending update is lost.
- No X propagation from Cond: all 16 encodings are decoded.

Decomposition:
- Shared package holds:
  - condition-code constants COND_EQ … COND_AL, 4-bit;
  - flag bit indices FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;
  - FlagW field meanings.
- One combinational sub-module, cond_check (Cond, Flags → CondEx), so the pure decode can be unit-tested exhaustively.
- The flags register and gating stay in the top.

Test Plan:
- Reset: hold Reset_n = 0 with Flags inputs toggling → Flags = 0000 and all write outputs 0. Release; Cond = 1110, RegW = 1 → RegWrite = 1.
- Update then branch:
  - Cycle 0: ALUFlags = 0100, FlagW = 11, Cond = 1110 (CMP, NoWrite = 1) → RegWrite = 0; Flags = 0100 after the edge.
  - Cycle 1: Cond = 0000, PCS = 1 → PCSrc = 1.
  - Same sequence with Cond = 0001 → PCSrc = 0.
- Partial update: Flags = 1010, ALUFlags = 0101, FlagW = 01, condition passes → Flags = 1001. Then FlagW = 10 with ALUFlags = 0100 → Flags = 0101.
- Condition fails: Flags = 0000, Cond = 0000 (EQ), ALUFlags = 1111, FlagW = 11, RegW = MemW = 1 → all writes 0 and Flags stays 0000.
- Stall/flush:
  - En = 0, Cond = AL, FlagW = 11, ALUFlags = 1111 → outputs 0, Flags unchanged.
  - Flush = 1 with En = 1 → same result.
  - Next cycle, En = 1 and Flush = 0 → update occurs.
- Exhaustive decode of cond_check: all 16 Cond values × 16 Flags values compared against a reference model. Spot checks:
  - GT with Flags = 1001 (N = V, Z = 0) → 1.
  - LE with Flags = 1000 → 1.
  - HI with Flags = 0110 → 0.
